instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: two-state FETCH/ISSUE sequencer that owns the PC,
// the current instruction register and the retired-instruction counter.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic [2:0]  funct3,
   output logic        funct7_5,
   output logic        instr_valid,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   input  logic        stall,
   output logic [31:0] instr_count
);

   typedef enum logic {
      FETCH = 1'b0,
      ISSUE = 1'b1
   } state_e;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] instr_q;
   logic [31:0] cnt_q;

   assign pc_plus4 = pc_q + 32'd4;

   // Redirect targets are forced word-aligned.
   always_comb begin
      pc_d = pc_plus4;
      if (pc_src)
         pc_d = pc_target & ~32'd3;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= NOP;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            FETCH: begin
               if (imem_ready) begin
                  instr_q <= imem_rdata;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (!stall) begin
                  pc_q    <= pc_d;
                  cnt_q   <= cnt_q + 32'd1;
                  state_q <= FETCH;
               end
            end
         endcase
      end
   end

   // Request is gated by rst so it stays low throughout reset.
   assign imem_req    = (state_q == FETCH) && !rst;
   assign instr_valid = (state_q == ISSUE);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_count = cnt_q;
   assign op          = instr_q[6:0];
   assign funct3      = instr_q[14:12];
   assign funct7_5    = instr_q[30];

endmodule
